// File: rtl/uart_why_core.sv
// ---------------------------------------------------------------------------
// uart_why_core
//
// Full-duplex 8N1 UART. Transmitter and receiver run independently but share
// one free-running 16x-oversampling baud tick.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset (0 = reset)
//   start      in   transmit request strobe, honoured only while TX is idle
//   tx_data    in   byte to transmit, captured when start is accepted
//   o_txd      out  serial output, idle high
//   o_tx_done  out  one-cycle pulse on the last tick of the stop bit
//   rx         in   asynchronous serial input, idle high
//   o_rx_data  out  last correctly framed byte received
//   o_rx_done  out  one-cycle pulse in the cycle o_rx_data updates
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for start
//   TX_START | start bit (0) for 16 ticks
//   TX_DATA  | data bits LSB first, 16 ticks each
//   TX_STOP  | stop bit (1) for 16 ticks, done on the last tick
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a low level on the synchronised line
//   RX_START | 8 ticks to mid start bit; high there means glitch
//   RX_DATA  | sample each data bit at mid-bit, 16 ticks apart
//   RX_STOP  | sample mid stop bit; high = good frame, low = framing error
// ---------------------------------------------------------------------------
module uart_why_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       o_txd,
    output logic       o_tx_done,
    input  logic       rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // -----------------------------------------------------------------------
    // Baud tick generator (free running, shared by TX and RX)
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t  r_tx_state;
    tx_state_t  w_tx_next;
    logic [3:0] r_tx_tick;
    logic [2:0] r_tx_bit;
    logic [7:0] r_tx_shift;
    logic       w_tx_bit_end;

    // Last tick of the current 16-tick bit cell.
    assign w_tx_bit_end = w_tick && (r_tx_tick == 4'd15);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (start)        w_tx_next = TX_START;
            TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_bit_end) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // Tick/bit counters and the shift register; the byte is captured only in
    // IDLE so later changes on tx_data cannot disturb a frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
        end else begin
            if (r_tx_state == TX_IDLE) begin
                r_tx_tick <= 4'd0;
                r_tx_bit  <= 3'd0;
                if (start) begin
                    r_tx_shift <= tx_data;
                end
            end else begin
                if (w_tick) begin
                    r_tx_tick <= r_tx_tick + 4'd1;
                end
                if ((r_tx_state == TX_DATA) && w_tx_bit_end) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    always_comb begin
        o_txd     = 1'b1;
        o_tx_done = 1'b0;
        case (r_tx_state)
            TX_IDLE:  o_txd = 1'b1;
            TX_START: o_txd = 1'b0;
            TX_DATA:  o_txd = r_tx_shift[0];
            TX_STOP:  begin
                o_txd     = 1'b1;
                o_tx_done = w_tx_bit_end;
            end
            default:  o_txd = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic       r_rx_meta;
    logic       r_rx_sync;
    logic       w_rx;
    rx_state_t  r_rx_state;
    rx_state_t  w_rx_next;
    logic [3:0] r_rx_tick;
    logic [2:0] r_rx_bit;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_done;
    logic       w_rx_mid;
    logic       w_rx_full;
    logic       w_rx_good;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx = r_rx_sync;

    // The tick counter restarts at the falling edge, so tick 8 lands mid start
    // bit and every 16 ticks after that lands mid data/stop bit.
    assign w_rx_mid  = w_tick && (r_rx_tick == 4'd7);
    assign w_rx_full = w_tick && (r_rx_tick == 4'd15);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!w_rx) w_rx_next = RX_START;
            RX_START: if (w_rx_mid) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_full) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_tick <= 4'd0;
                    r_rx_bit  <= 3'd0;
                end
                RX_START: begin
                    if (w_rx_mid) begin
                        r_rx_tick <= 4'd0;
                    end else if (w_tick) begin
                        r_rx_tick <= r_rx_tick + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_rx_tick <= r_rx_tick + 4'd1;
                    end
                    if (w_rx_full) begin
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_rx_tick <= r_rx_tick + 4'd1;
                    end
                end
                default: begin
                    r_rx_tick <= 4'd0;
                    r_rx_bit  <= 3'd0;
                end
            endcase
        end
    end

    // A frame is good only if the mid-stop-bit sample is high.
    always_comb begin
        w_rx_good = 1'b0;
        if ((r_rx_state == RX_STOP) && w_rx_full && w_rx) begin
            w_rx_good = 1'b1;
        end
    end

    // Data and done are registered together so the byte changes in exactly
    // the cycle the pulse is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data <= 8'h00;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= w_rx_good;
            if (w_rx_good) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_rx_done = r_rx_done;

endmodule

// File: tb/tb_uart_why_core.sv
module tb_uart_why_core;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 1_562_500;   // DIV = 4
    localparam int DIV      = 4;
    localparam int BP       = 16 * DIV;    // clk cycles per bit

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       o_txd;
    logic       o_tx_done;
    logic       rx;
    logic [7:0] o_rx_data;
    logic       o_rx_done;

    logic lb     = 1'b1;   // 1: o_txd looped to rx
    logic rx_drv = 1'b1;

    assign rx = lb ? o_txd : rx_drv;

    uart_why_core #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .o_txd    (o_txd),
        .o_tx_done(o_tx_done),
        .rx       (rx),
        .o_rx_data(o_rx_data),
        .o_rx_done(o_rx_done)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         rx_cnt   = 0;
    int         tx_cnt   = 0;
    int         stab_err = 0;
    logic       prev_rxd = 1'b0;
    logic       prev_txd = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops an expected byte every time the DUT reports one.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (o_rx_done) begin
                rx_cnt++;
                chk("rx_done_width", 32'(prev_rxd), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", o_rx_data);
                end else begin
                    chk("rx_data", 32'(o_rx_data), 32'(exp_q.pop_front()));
                end
            end else if (o_rx_data !== prev_data) begin
                stab_err++;
            end
            if (o_tx_done) begin
                tx_cnt++;
                chk("tx_done_width", 32'(prev_txd), 32'd0);
            end
        end
        prev_rxd  = o_rx_done;
        prev_txd  = o_tx_done;
        prev_data = o_rx_data;
    end

    // Send one byte in loopback; decode the line at mid-bit against the 8N1
    // frame and wait for tx_done. Optionally strobe start mid-frame with 8'h55.
    task automatic send(input logic [7:0] b, input bit inject);
        logic [9:0] fr;
        int         c;
        int         k;
        int         rx0;
        bit         seen;
        fr = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        rx0 = rx_cnt;
        @(negedge clk);
        tx_data = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'($urandom_range(0, 255));
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 170 * DIV) begin
            if (c > 0) @(negedge clk);
            c++;
            if (c >= 33 && ((c - 33) % BP) == 0 && ((c - 33) / BP) < 10) begin
                k = (c - 33) / BP;
                chk($sformatf("line_bit%0d", k), 32'(o_txd), 32'(fr[k]));
            end
            if (inject && c == 5 * BP) begin
                start   = 1'b1;
                tx_data = 8'h55;
            end
            if (inject && c == 5 * BP + 1) start = 1'b0;
            if (o_tx_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tx_done_timeout actual=none required=pulse");
        end else if (c < 159 * DIV || c > 161 * DIV) begin
            failures++;
            $display("FAIL tx_done_latency actual=%0d required=%0d..%0d", c, 159 * DIV, 161 * DIV);
        end
        chk("rx_before_tx", 32'(rx_cnt), 32'(rx0 + 1));
    endtask

    // Drive a frame directly on rx. A bad frame holds its stop bit low for
    // 3/4 of a bit, then idles high.
    task automatic drive_frame(input logic [7:0] b, input bit good);
        lb = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BP) @(negedge clk);
        end
        if (good) begin
            rx_drv = 1'b1;
            repeat (3 * BP) @(negedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (3 * BP / 4) @(negedge clk);
            rx_drv = 1'b1;
            repeat (3 * BP) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] d0;
        int         r0;
        int         t0;
        int         w;

        // Reset held for one cycle, then released.
        @(negedge clk);
        chk("rst_txd",     32'(o_txd),     32'd1);
        chk("rst_tx_done", 32'(o_tx_done), 32'd0);
        chk("rst_rx_data", 32'(o_rx_data), 32'd0);
        chk("rst_rx_done", 32'(o_rx_done), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Directed loopback bytes, then back-to-back 00/FF.
        send(8'h01, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);

        // Mid-frame start must be ignored: one frame, one done.
        t0 = tx_cnt;
        send(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        chk("inject_tx_done_count", 32'(tx_cnt), 32'(t0 + 1));
        repeat (BP) @(negedge clk);
        chk("inject_no_extra_frame", 32'(o_txd), 32'd1);

        // Random loopback bytes.
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), 1'b0);
        end

        // Glitch: 4 ticks low then high.
        lb = 1'b0;
        r0 = rx_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * BP) @(negedge clk);
        chk("glitch_no_rx_done", 32'(rx_cnt), 32'(r0));

        // Framing error: stop bit low.
        d0 = o_rx_data;
        r0 = rx_cnt;
        drive_frame(8'h5A, 1'b0);
        chk("frame_err_no_done",   32'(rx_cnt),    32'(r0));
        chk("frame_err_data_hold", 32'(o_rx_data), 32'(d0));

        // Good frames driven externally.
        r0 = rx_cnt;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            drive_frame(b, 1'b1);
        end
        chk("driven_rx_count", 32'(rx_cnt), 32'(r0 + 3));

        // Reset in the middle of a loopback frame (TX and RX both busy).
        lb = 1'b1;
        t0 = tx_cnt;
        r0 = rx_cnt;
        @(negedge clk);
        tx_data = 8'h77;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (3 * BP) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_txd",     32'(o_txd),     32'd1);
        chk("abort_tx_done", 32'(o_tx_done), 32'd0);
        chk("abort_rx_done", 32'(o_rx_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rx_data", 32'(o_rx_data), 32'd0);
        repeat (12 * BP) @(negedge clk);
        chk("abort_txd_idle",   32'(o_txd),  32'd1);
        chk("abort_no_tx_done", 32'(tx_cnt), 32'(t0));
        chk("abort_no_rx_done", 32'(rx_cnt), 32'(r0));

        send(8'h3C, 1'b0);

        w = 0;
        while (exp_q.size() != 0 && w < 20 * BP) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("rx_data_stable",     32'(stab_err),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
